bus_multi_timer: RTL

Multi-channel successor to the single-interval bus timer, mapped on the 8-bit processor bus at BASE_ADDR..BASE_ADDR+15. A shared prescaler generates a tick, and a TICK_W free-running tick counter is readable atomically as two bytes. NUM_CH independent channels each have a 16-bit interval, periodic or one-shot mode, and a per-channel interrupt enable. Pending flags are visible in a status register and clear by write-1 or by BUS_INTERRUPT_ACK.

---
 rtl/bus_multi_timer_pkg.sv | 29 ++
 rtl/bus_multi_timer_if.sv | 21 ++
 rtl/bus_multi_timer_channel.sv | 85 ++++++++
 rtl/bus_multi_timer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/bus_multi_timer_pkg.sv
// Shared register map constants and bit indices for the multi-channel bus timer.
package timer_pkg;

  localparam int unsigned WIN_SIZE    = 16;

  localparam int unsigned OFF_TICK_LO = 0;
  localparam int unsigned OFF_TICK_HI = 1;
  localparam int unsigned OFF_CTRL    = 2;
  localparam int unsigned OFF_STATUS  = 3;
  localparam int unsigned OFF_CH0     = 4;
  localparam int unsigned CH_STRIDE   = 3;

  localparam int unsigned CH_REG_LO   = 0;
  localparam int unsigned CH_REG_HI   = 1;
  localparam int unsigned CH_REG_CTRL = 2;

  localparam int unsigned CH_EN       = 0;
  localparam int unsigned CH_ONESHOT  = 1;
  localparam int unsigned CH_IRQ_EN   = 2;

  localparam int unsigned CTRL_GEN    = 0;
  localparam int unsigned CTRL_TCLR   = 7;

  // Window offset of register reg_idx belonging to channel ch.
  function automatic logic [3:0] ch_off(input int unsigned ch, input int unsigned reg_idx);
    return 4'(OFF_CH0 + CH_STRIDE * ch + reg_idx);
  endfunction

endpackage

// File: rtl/bus_multi_timer_if.sv
// Processor bus control/interrupt signals of the timer; the data bus stays a plain inout.
interface bus_multi_timer_if;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic       BUS_INTERRUPT_RAISE;
  logic       BUS_INTERRUPT_ACK;

  modport master (
    output BUS_ADDR,
    output BUS_WE,
    output BUS_INTERRUPT_ACK,
    input  BUS_INTERRUPT_RAISE
  );

  modport slave (
    input  BUS_ADDR,
    input  BUS_WE,
    input  BUS_INTERRUPT_ACK,
    output BUS_INTERRUPT_RAISE
  );
endinterface

// File: rtl/bus_multi_timer_channel.sv
// One timer channel: interval/control registers, tick count and a fire pulse.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned INTERVAL_W = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       tick_pulse,
  input  logic       gen_en,
  input  logic       wr_lo,
  input  logic       wr_hi,
  input  logic       wr_ctrl,
  input  logic [7:0] wr_data,
  output logic       fire_c,
  output logic       irq_en,
  output logic [7:0] rd_lo,
  output logic [7:0] rd_hi,
  output logic [7:0] rd_ctrl
);

  localparam int unsigned HI_W  = INTERVAL_W - 8;
  localparam int unsigned CNT_W = INTERVAL_W + 1;

  logic [INTERVAL_W-1:0] interval_q, interval_d;
  logic [INTERVAL_W-1:0] cnt_q, cnt_d;
  logic                  en_q, en_d;
  logic                  oneshot_q, oneshot_d;
  logic                  irq_en_q, irq_en_d;
  logic [CNT_W-1:0]      cnt_inc_c;

  // Count ticks, fire and restart; register writes override the counting path.
  always_comb begin
    interval_d = interval_q;
    cnt_d      = cnt_q;
    en_d       = en_q;
    oneshot_d  = oneshot_q;
    irq_en_d   = irq_en_q;
    fire_c     = 1'b0;
    cnt_inc_c  = {1'b0, cnt_q} + CNT_W'(1);

    if (en_q && gen_en && tick_pulse && (interval_q != '0)) begin
      if (cnt_inc_c >= {1'b0, interval_q}) begin
        fire_c = 1'b1;
        cnt_d  = '0;
        if (oneshot_q) en_d = 1'b0;
      end else begin
        cnt_d = cnt_inc_c[INTERVAL_W-1:0];
      end
    end

    if (interval_q == '0) cnt_d = '0;

    if (wr_lo) interval_d[7:0] = wr_data;
    if (wr_hi) interval_d[INTERVAL_W-1:8] = wr_data[HI_W-1:0];
    if (wr_ctrl) begin
      en_d      = wr_data[CH_EN];
      oneshot_d = wr_data[CH_ONESHOT];
      irq_en_d  = wr_data[CH_IRQ_EN];
      if (!en_q && wr_data[CH_EN]) cnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      interval_q <= '0;
      cnt_q      <= '0;
      en_q       <= 1'b0;
      oneshot_q  <= 1'b0;
      irq_en_q   <= 1'b0;
    end else begin
      interval_q <= interval_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      oneshot_q  <= oneshot_d;
      irq_en_q   <= irq_en_d;
    end
  end

  assign irq_en  = irq_en_q;
  assign rd_lo   = interval_q[7:0];
  assign rd_hi   = 8'(interval_q[INTERVAL_W-1:8]);
  assign rd_ctrl = {5'b0, irq_en_q, oneshot_q, en_q};

endmodule

// File: rtl/bus_multi_timer.sv
// Multi-channel bus timer: shared prescaler and tick counter, NUM_CH interval channels,
// pending/interrupt logic and the registered, tristated read path.
module bus_multi_timer
  import timer_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR  = 8'hF0,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned TICK_W     = 16,
  parameter int unsigned INTERVAL_W = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  inout  wire  [7:0]         BUS_DATA,
  bus_multi_timer_if.slave   bus
);

  localparam int unsigned PRESC_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SHADOW_W = TICK_W - 8;

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [SHADOW_W-1:0] shadow_q, shadow_d;
  logic                gen_en_q, gen_en_d;
  logic [NUM_CH-1:0]   pending_q, pending_d;
  logic                raise_q, raise_d;
  logic                rd_valid_q, rd_valid_d;
  logic [7:0]          rd_data_q, rd_data_d;

  logic [8:0]          addr_diff_c;
  logic                in_win_c;
  logic [3:0]          off_c;
  logic                wr_c;
  logic                rd_c;
  logic                tick_pulse_c;
  logic [7:0]          wr_data_c;

  logic [NUM_CH-1:0]   fire_c;
  logic [NUM_CH-1:0]   irq_en;
  logic [NUM_CH-1:0]   ch_wr_lo_c;
  logic [NUM_CH-1:0]   ch_wr_hi_c;
  logic [NUM_CH-1:0]   ch_wr_ctrl_c;
  logic [7:0]          ch_lo   [NUM_CH];
  logic [7:0]          ch_hi   [NUM_CH];
  logic [7:0]          ch_ctrl [NUM_CH];

  // Borrow-aware subtract so an unaligned BASE_ADDR still decodes a 16-byte window.
  assign addr_diff_c  = {1'b0, bus.BUS_ADDR} - {1'b0, BASE_ADDR};
  assign in_win_c     = (addr_diff_c[8:4] == 5'd0);
  assign off_c        = addr_diff_c[3:0];
  assign wr_c         = in_win_c & bus.BUS_WE;
  assign rd_c         = in_win_c & ~bus.BUS_WE;
  assign wr_data_c    = BUS_DATA;
  assign tick_pulse_c = (presc_q == PRESC_W'(TICK_DIV - 1));

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    assign ch_wr_lo_c[n]   = wr_c && (off_c == ch_off(n, CH_REG_LO));
    assign ch_wr_hi_c[n]   = wr_c && (off_c == ch_off(n, CH_REG_HI));
    assign ch_wr_ctrl_c[n] = wr_c && (off_c == ch_off(n, CH_REG_CTRL));

    timer_channel #(
      .INTERVAL_W (INTERVAL_W)
    ) u_ch (
      .CLK        (CLK),
      .RESET      (RESET),
      .tick_pulse (tick_pulse_c),
      .gen_en     (gen_en_q),
      .wr_lo      (ch_wr_lo_c[n]),
      .wr_hi      (ch_wr_hi_c[n]),
      .wr_ctrl    (ch_wr_ctrl_c[n]),
      .wr_data    (wr_data_c),
      .fire_c     (fire_c[n]),
      .irq_en     (irq_en[n]),
      .rd_lo      (ch_lo[n]),
      .rd_hi      (ch_hi[n]),
      .rd_ctrl    (ch_ctrl[n])
    );
  end

  always_comb begin
    presc_d    = presc_q;
    tick_d     = tick_q;
    shadow_d   = shadow_q;
    gen_en_d   = gen_en_q;
    pending_d  = pending_q;
    raise_d    = |(pending_q & irq_en);
    rd_valid_d = rd_c;
    rd_data_d  = 8'h00;

    if (tick_pulse_c) presc_d = '0;
    else              presc_d = presc_q + PRESC_W'(1);
    if (tick_pulse_c && gen_en_q) tick_d = tick_q + TICK_W'(1);

    // Tick clear overrides a coincident tick increment.
    if (wr_c && (off_c == 4'(OFF_CTRL))) begin
      gen_en_d = wr_data_c[CTRL_GEN];
      if (wr_data_c[CTRL_TCLR]) begin
        presc_d = '0;
        tick_d  = '0;
      end
    end

    // New fires are OR-ed in last so a set beats a same-edge clear.
    if (bus.BUS_INTERRUPT_ACK)                  pending_d = '0;
    else if (wr_c && (off_c == 4'(OFF_STATUS))) pending_d = pending_q & ~wr_data_c[NUM_CH-1:0];
    pending_d = pending_d | fire_c;

    if (rd_c) begin
      if (off_c == 4'(OFF_TICK_LO)) begin
        rd_data_d = tick_q[7:0];
        shadow_d  = tick_q[TICK_W-1:8];
      end else if (off_c == 4'(OFF_TICK_HI)) begin
        rd_data_d = 8'(shadow_q);
      end else if (off_c == 4'(OFF_STATUS)) begin
        rd_data_d = 8'(pending_q);
      end
      for (int n = 0; n < NUM_CH; n++) begin
        if (off_c == ch_off(n, CH_REG_LO))   rd_data_d = ch_lo[n];
        if (off_c == ch_off(n, CH_REG_HI))   rd_data_d = ch_hi[n];
        if (off_c == ch_off(n, CH_REG_CTRL)) rd_data_d = ch_ctrl[n];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc_q    <= '0;
      tick_q     <= '0;
      shadow_q   <= '0;
      gen_en_q   <= 1'b1;
      pending_q  <= '0;
      raise_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      shadow_q   <= shadow_d;
      gen_en_q   <= gen_en_d;
      pending_q  <= pending_d;
      raise_q    <= raise_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign BUS_DATA                = rd_valid_q ? rd_data_q : 8'hzz;
  assign bus.BUS_INTERRUPT_RAISE = raise_q;

endmodule
